// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for fetch (I) and load/store (D) requesters
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed D priority with a fetch starvation guard.
module mem_port_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic            i_done,
   output logic [DW-1:0]   i_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_be,
   output logic            d_done,
   output logic [DW-1:0]   d_rdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_be,
   input  logic [DW-1:0]   mem_rdata,
   input  logic            mem_ready,
   output logic            owner
);

   localparam int BW = DW / 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_grant;
   logic            w_grant_d;
   logic            w_complete;
   logic            r_owner;
   logic            r_mem_req;
   logic            r_mem_we;
   logic [AW-1:0]   r_mem_addr;
   logic [DW-1:0]   r_mem_wdata;
   logic [BW-1:0]   r_mem_be;
   logic [DW-1:0]   r_i_rdata;
   logic [DW-1:0]   r_d_rdata;

`ifdef MEM_ARB_RR_EN
   logic            r_last_d;
`else
   localparam logic [3:0] LP_SMAX = 4'(STARVE_MAX);
   logic [3:0]      r_starve;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_grant_d   = 1'b0;
      w_complete  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_req || d_req) begin
               w_grant     = 1'b1;
               w_state_nxt = S_ISSUE;
               if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
                  w_grant_d = !r_last_d;
`else
                  // fetch wins only once D has taken STARVE_MAX grants in a row over it
                  w_grant_d = (r_starve != LP_SMAX);
`endif
               end else begin
                  w_grant_d = d_req;
               end
            end
         end
         S_ISSUE: begin
            if (mem_ready) begin
               w_complete  = 1'b1;
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner     <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
         r_i_rdata   <= '0;
         r_d_rdata   <= '0;
      end else begin
         if (w_grant) begin
            r_mem_req  <= 1'b1;
            r_owner    <= w_grant_d;
            r_mem_addr <= w_grant_d ? d_addr : i_addr;
            if (w_grant_d && d_we) begin
               r_mem_we    <= 1'b1;
               r_mem_wdata <= d_wdata;
               r_mem_be    <= d_be;
            end else begin
               r_mem_we    <= 1'b0;
               r_mem_wdata <= '0;
               r_mem_be    <= '1;
            end
         end
         if (w_complete) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_be  <= '0;
            // stores also capture mem_rdata into d_rdata
            if (r_owner) begin
               r_d_rdata <= mem_rdata;
            end else begin
               r_i_rdata <= mem_rdata;
            end
         end
      end
   end

`ifdef MEM_ARB_RR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_d <= 1'b0;
      end else if (w_grant) begin
         r_last_d <= w_grant_d;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve <= '0;
      end else if (w_grant) begin
         if (w_grant_d && i_req) begin
            if (r_starve != LP_SMAX) begin
               r_starve <= r_starve + 4'd1;
            end
         end else begin
            r_starve <= '0;
         end
      end
   end
`endif

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_be    = r_mem_be;
   assign owner     = r_owner;
   assign i_rdata   = r_i_rdata;
   assign d_rdata   = r_d_rdata;
   assign i_done    = (r_state == S_RESP) && !r_owner;
   assign d_done    = (r_state == S_RESP) && r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized scoreboard bench for mem_port_arbiter
// Honours MEM_ARB_RR_EN to select the matching arbitration reference model.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SM = 4;
   localparam int BW = DW / 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic          i_done;
   logic [DW-1:0] i_rdata;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [BW-1:0] d_be = '0;
   logic          d_done;
   logic [DW-1:0] d_rdata;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [BW-1:0] mem_be;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ready = 1'b0;
   logic          owner;

   mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_done(d_done), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .owner(owner)
   );

   always #5 clk = ~clk;

   int            total = 0;
   int            bad = 0;
   logic [DW:0]   sbq[$];
   int            lat_min = 0;
   int            lat_max = 2;
   int            starve_m = 0;
   bit            last_d_m = 1'b0;
   logic [DW-1:0] exp_i = '0;
   logic [DW-1:0] exp_d = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // memory model: random latency per access, stray mem_ready while idle
   bit act_m = 1'b0;
   int cd = 0;
   always begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
         act_m = 1'b0;
         mem_ready = 1'b0;
      end else if (mem_req) begin
         if (!act_m) begin
            act_m = 1'b1;
            cd = $urandom_range(lat_max, lat_min);
         end
         if (cd == 0) begin
            mem_ready = 1'b1;
            mem_rdata = $urandom;
            sbq.push_back({owner, mem_rdata});
         end else begin
            mem_ready = 1'b0;
            cd--;
         end
      end else begin
         act_m = 1'b0;
         mem_ready = ($urandom_range(3, 0) == 0);
         mem_rdata = $urandom;
      end
   end

   logic          p_ireq = 0, p_dreq = 0, p_dwe = 0, p_memreq = 0;
   logic [AW-1:0] p_iaddr = '0, p_daddr = '0, h_addr = '0;
   logic [DW-1:0] p_dwdata = '0, h_wdata = '0;
   logic [BW-1:0] p_dbe = '0;
   logic [BW+1:0] h_ctl = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         starve_m = 0;
         last_d_m = 1'b0;
         sbq.delete();
         exp_i = '0;
         exp_d = '0;
      end else begin
         if (mem_req && !p_memreq) begin
            bit gd;
            bit st;
            chk("grant_had_req", 64'(p_ireq | p_dreq), 64'd1);
            if (p_ireq && p_dreq) begin
`ifdef MEM_ARB_RR_EN
               gd = !last_d_m;
`else
               gd = (starve_m != SM);
`endif
            end else begin
               gd = p_dreq;
            end
`ifdef MEM_ARB_RR_EN
            last_d_m = gd;
`else
            if (gd && p_ireq) starve_m = (starve_m < SM) ? starve_m + 1 : SM;
            else starve_m = 0;
`endif
            st = gd && p_dwe;
            chk("grant_owner", 64'(owner), 64'(gd));
            chk("grant_addr", 64'(mem_addr), 64'(gd ? p_daddr : p_iaddr));
            chk("grant_we", 64'(mem_we), 64'(st));
            chk("grant_be", 64'(mem_be), 64'(st ? p_dbe : {BW{1'b1}}));
            chk("grant_wdata", 64'(mem_wdata), 64'(st ? p_dwdata : '0));
            h_addr  = mem_addr;
            h_wdata = mem_wdata;
            h_ctl   = {owner, mem_we, mem_be};
         end else if (mem_req && p_memreq) begin
            chk("hold_addr", 64'(mem_addr), 64'(h_addr));
            chk("hold_wdata", 64'(mem_wdata), 64'(h_wdata));
            chk("hold_ctl", 64'({owner, mem_we, mem_be}), 64'(h_ctl));
         end
         chk("done_exclusive", 64'(i_done & d_done), 64'd0);
         if (i_done || d_done) begin
            chk("done_has_access", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
               logic [DW:0] e;
               e = sbq.pop_front();
               chk("done_owner", 64'(d_done), 64'(e[DW]));
               if (e[DW]) exp_d = e[DW-1:0];
               else exp_i = e[DW-1:0];
            end
         end
         chk("i_rdata", 64'(i_rdata), 64'(exp_i));
         chk("d_rdata", 64'(d_rdata), 64'(exp_d));
      end
      p_ireq   = i_req;
      p_dreq   = d_req;
      p_iaddr  = i_addr;
      p_daddr  = d_addr;
      p_dwe    = d_we;
      p_dwdata = d_wdata;
      p_dbe    = d_be;
      p_memreq = mem_req;
   end

   task automatic wait_i();
      int c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!i_done && c < 300);
      chk("i_done_timeout", 64'(i_done), 64'd1);
   endtask

   task automatic wait_d();
      int c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!d_done && c < 300);
      chk("d_done_timeout", 64'(d_done), 64'd1);
   endtask

   task automatic drive_i(input int n, input int gmax);
      for (int k = 0; k < n; k++) begin
         i_addr = $urandom;
         i_req  = 1'b1;
         wait_i();
         @(posedge clk);
         #1;
         i_req = 1'b0;
         repeat ($urandom_range(gmax, 0)) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic drive_d(input int n, input int gmax);
      for (int k = 0; k < n; k++) begin
         d_addr  = $urandom;
         d_we    = $urandom_range(1, 0) == 1;
         d_wdata = $urandom;
         d_be    = BW'($urandom);
         d_req   = 1'b1;
         wait_d();
         @(posedge clk);
         #1;
         d_req = 1'b0;
         repeat ($urandom_range(gmax, 0)) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_outputs", 64'({i_done, d_done, owner, mem_we, mem_be}), 64'd0);
      chk("rst_rdata", 64'({i_rdata, d_rdata}), 64'd0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      lat_max = 2;
      fork
         drive_i(6, 0);
         drive_d(30, 0);
      join
      lat_max = 10;
      fork
         drive_i(40, 3);
         drive_d(40, 3);
      join
      repeat (5) @(posedge clk);
      #1;

      lat_min = 5;
      lat_max = 8;
      i_addr  = 32'h100;
      i_req   = 1'b1;
      begin
         int c = 0;
         do begin
            @(negedge clk);
            c++;
         end while (!mem_req && c < 20);
      end
      chk("rst_test_issue", 64'(mem_req), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_mem_req", 64'(mem_req), 64'd0);
      chk("async_rst_done", 64'({i_done, d_done}), 64'd0);
      chk("async_rst_rdata", 64'({i_rdata, d_rdata}), 64'd0);
      chk("async_rst_mem", 64'({owner, mem_we, mem_be, mem_addr}), 64'd0);
      @(negedge clk);
      #2;
      rst_n   = 1'b1;
      lat_min = 0;
      lat_max = 2;
      wait_i();
      @(posedge clk);
      #1;
      i_req = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("sb_drained", 64'(sbq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
